reel_bank: RTL

// - Four symbol "reels" feeding the game FSM's letter0..letter3 inputs and the 7-segment path.
// - Consumes the FSM's per-reel stop_flag: a reel spins while its flag is 1 and freezes when it is 0.
// - Reels advance at skewed rates, so a four-way match depends on when the player presses the keys.

---
 rtl/reel_bank_pkg.sv | 33 +++
 rtl/reel_bank_counter.sv | 55 +++++
 rtl/reel_bank.sv | 58 +++++
 3 files changed

// File: rtl/reel_bank_pkg.sv
// ---------------------------------------------------------------------------
// reel_bank_pkg
// Shared definitions for the slot-game datapath: symbol and message widths,
// the FSM message codes, the reel count, and the symbol-advance helper that
// every reel uses.
// No ports (package).
// ---------------------------------------------------------------------------
package reel_bank_pkg;

    localparam int SYM_W     = 4;   // letter width
    localparam int MSG_W     = 5;   // FSM message width
    localparam int NUM_REELS = 4;

    // FSM message codes 'h10..'h15
    localparam logic [MSG_W-1:0] MSG_CODE_0 = 5'h10;
    localparam logic [MSG_W-1:0] MSG_CODE_1 = 5'h11;
    localparam logic [MSG_W-1:0] MSG_CODE_2 = 5'h12;
    localparam logic [MSG_W-1:0] MSG_CODE_3 = 5'h13;
    localparam logic [MSG_W-1:0] MSG_CODE_4 = 5'h14;
    localparam logic [MSG_W-1:0] MSG_CODE_5 = 5'h15;

    typedef logic [SYM_W-1:0] sym_t;

    // Next symbol on a reel. An out-of-range value above max_sym simply keeps
    // counting and falls back to 0 through the natural 4-bit overflow at 15.
    function automatic sym_t next_symbol(input sym_t v, input sym_t max_sym);
        if (v == max_sym) begin
            return '0;
        end
        return v + sym_t'(1);
    endfunction

endpackage

// File: rtl/reel_bank_counter.sv
// ---------------------------------------------------------------------------
// reel_counter
// One reel: a prescaler, a symbol register and a one-cycle step pulse.
// While run is high the prescaler counts 0..PERIOD-1; on the terminal count
// the symbol advances (wrapping MAX_SYMBOL -> 0) and step pulses the cycle
// after. Dropping run clears the prescaler and freezes the symbol, so a later
// restart always takes a full PERIOD before the first advance.
// Ports:
//   clk     in   1      system clock
//   reset   in   1      synchronous, active-high
//   run     in   1      1 = spin, 0 = frozen
//   symbol  out  SYM_W  current symbol (registered)
//   step    out  1      high in the cycle after the symbol advanced
// ---------------------------------------------------------------------------
module reel_counter
    import reel_bank_pkg::*;
#(
    parameter int PERIOD     = 4,
    parameter int MAX_SYMBOL = 9,
    parameter int INIT       = 0,
    parameter int PC_W       = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    output sym_t symbol,
    output logic step
);

    localparam logic [PC_W-1:0] PC_LAST = PC_W'(PERIOD - 1);
    localparam sym_t            SYM_MAX = SYM_W'(MAX_SYMBOL);
    localparam sym_t            SYM_INIT = SYM_W'(INIT);

    logic [PC_W-1:0] pc;

    always_ff @(posedge clk) begin
        if (reset) begin
            pc     <= '0;
            symbol <= SYM_INIT;
            step   <= 1'b0;
        end else if (!run) begin
            // Stop wins over a coincident terminal count: no advance, no pulse.
            pc   <= '0;
            step <= 1'b0;
        end else if (pc == PC_LAST) begin
            pc     <= '0;
            symbol <= next_symbol(symbol, SYM_MAX);
            step   <= 1'b1;
        end else begin
            pc   <= pc + PC_W'(1);
            step <= 1'b0;
        end
    end

endmodule

// File: rtl/reel_bank.sv
// ---------------------------------------------------------------------------
// reel_bank
// Four independent symbol reels feeding the game FSM (letter0..letter3) and
// the 7-segment path. Reel i spins while stop_flag[i] is 1 with period
// TICK_DIV + i*TICK_SKEW clocks, so the reels drift relative to each other
// and a four-way match depends on when the player stops them.
// Reset loads letters 0,1,2,3 so the idle display is never a match.
// This level is wiring only; all state is inside reel_counter.
// Ports:
//   clk        in   1  system clock
//   reset      in   1  synchronous, active-high
//   stop_flag  in   4  per-reel run enable (1 = spin, 0 = frozen)
//   letter0-3  out  4  reel symbols (registered)
//   reel_step  out  4  bit i pulses for one cycle after reel i advanced
// ---------------------------------------------------------------------------
module reel_bank
    import reel_bank_pkg::*;
#(
    parameter int TICK_DIV   = 50000,
    parameter int TICK_SKEW  = 7919,
    parameter int MAX_SYMBOL = 9
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] stop_flag,
    output logic [3:0] letter0,
    output logic [3:0] letter1,
    output logic [3:0] letter2,
    output logic [3:0] letter3,
    output logic [3:0] reel_step
);

    // Sized for the slowest reel so every prescaler shares one width.
    localparam int PC_W = $clog2(TICK_DIV + 3 * TICK_SKEW);

    sym_t letters [NUM_REELS];

    for (genvar i = 0; i < NUM_REELS; i++) begin : g_reel
        reel_counter #(
            .PERIOD     (TICK_DIV + i * TICK_SKEW),
            .MAX_SYMBOL (MAX_SYMBOL),
            .INIT       (i),
            .PC_W       (PC_W)
        ) u_reel (
            .clk    (clk),
            .reset  (reset),
            .run    (stop_flag[i]),
            .symbol (letters[i]),
            .step   (reel_step[i])
        );
    end

    assign letter0 = letters[0];
    assign letter1 = letters[1];
    assign letter2 = letters[2];
    assign letter3 = letters[3];

endmodule
